// File: rtl/frame_stream_tx.sv
// Frames an unframed pixel-beat stream into fixed-size frames (tuser on first beat,
// tlast on last beat) for a requested number of frames, through a 2-entry skid buffer.
module frame_stream_tx #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM       = 512,
  parameter int DATA_WIDTH      = 8*PIXELS_PER_BEAT,
  parameter int MAX_FRAMES      = 16
) (
  input  logic                          s_axis_aclk,
  input  logic                          s_axis_aresetn,
  input  logic                          start,
  input  logic [$clog2(MAX_FRAMES):0]   num_frames,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  output logic [$clog2(MAX_FRAMES)-1:0] frame_index,
  output logic                          busy,
  output logic                          done
);

  localparam int BEATS_PER_FRAME = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT;
  localparam int BCW = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;
  localparam int NFW = $clog2(MAX_FRAMES) + 1;
  localparam int FIW = $clog2(MAX_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [BCW-1:0]        r_beat_cnt;
  logic [BCW-1:0]        w_beat_next;
  logic [FIW-1:0]        r_frame_index;
  logic [FIW-1:0]        w_frame_next;
  logic [NFW-1:0]        r_num_frames;
  logic [NFW-1:0]        w_nf_next;

  logic                  r_s_ready;
  logic                  w_s_ready_next;
  logic                  r_done;
  logic                  w_done_next;

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_last;
  logic                  r_out_user;
  logic                  w_out_valid_next;
  logic [DATA_WIDTH-1:0] w_out_data_next;
  logic                  w_out_last_next;
  logic                  w_out_user_next;

  logic                  r_skid_valid;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic                  r_skid_last;
  logic                  r_skid_user;
  logic                  w_skid_valid_next;
  logic [DATA_WIDTH-1:0] w_skid_data_next;
  logic                  w_skid_last_next;
  logic                  w_skid_user_next;

  logic                  w_in_step;
  logic                  w_out_step;
  logic                  w_tag_last;
  logic                  w_tag_user;
  logic                  w_last_frame;
  logic                  w_start_ok;

  assign w_in_step    = s_axis_tvalid & r_s_ready;
  assign w_out_step   = r_out_valid & m_axis_tready;
  assign w_tag_last   = (r_beat_cnt == BCW'(BEATS_PER_FRAME - 1));
  assign w_tag_user   = (r_beat_cnt == '0);
  assign w_last_frame = ({1'b0, r_frame_index} == (r_num_frames - NFW'(1)));
  assign w_start_ok   = start && (r_state == S_IDLE) && (num_frames != '0) &&
                        (num_frames <= NFW'(MAX_FRAMES));

  always_comb begin
    w_state_next      = r_state;
    w_done_next       = 1'b0;
    w_beat_next       = r_beat_cnt;
    w_frame_next      = r_frame_index;
    w_nf_next         = r_num_frames;
    w_out_valid_next  = r_out_valid;
    w_out_data_next   = r_out_data;
    w_out_last_next   = r_out_last;
    w_out_user_next   = r_out_user;
    w_skid_valid_next = r_skid_valid;
    w_skid_data_next  = r_skid_data;
    w_skid_last_next  = r_skid_last;
    w_skid_user_next  = r_skid_user;

    if (w_out_step) begin
      if (r_skid_valid) begin
        w_out_data_next   = r_skid_data;
        w_out_last_next   = r_skid_last;
        w_out_user_next   = r_skid_user;
        w_skid_valid_next = 1'b0;
      end else begin
        w_out_valid_next  = 1'b0;
      end
    end

    // An accepted beat implies the skid was empty, so it never collides with a skid move.
    if (w_in_step) begin
      if (!r_out_valid || w_out_step) begin
        w_out_valid_next  = 1'b1;
        w_out_data_next   = s_axis_tdata;
        w_out_last_next   = w_tag_last;
        w_out_user_next   = w_tag_user;
      end else begin
        w_skid_valid_next = 1'b1;
        w_skid_data_next  = s_axis_tdata;
        w_skid_last_next  = w_tag_last;
        w_skid_user_next  = w_tag_user;
      end
      w_beat_next = w_tag_last ? '0 : r_beat_cnt + BCW'(1);
      if (w_tag_last) begin
        w_frame_next = r_frame_index + FIW'(1);
      end
    end

    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_next = S_STREAM;
          w_beat_next  = '0;
          w_frame_next = '0;
          w_nf_next    = num_frames;
        end
      end
      S_STREAM: begin
        if (w_in_step && w_tag_last && w_last_frame) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave as soon as the final beat is leaving, so done follows it by one cycle.
        if (!w_out_valid_next && !w_skid_valid_next) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    w_s_ready_next = (w_state_next == S_STREAM) && !w_skid_valid_next;
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_state       <= S_IDLE;
      r_beat_cnt    <= '0;
      r_frame_index <= '0;
      r_num_frames  <= '0;
      r_s_ready     <= 1'b0;
      r_done        <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_last    <= 1'b0;
      r_out_user    <= 1'b0;
      r_skid_valid  <= 1'b0;
      r_skid_data   <= '0;
      r_skid_last   <= 1'b0;
      r_skid_user   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_beat_cnt    <= w_beat_next;
      r_frame_index <= w_frame_next;
      r_num_frames  <= w_nf_next;
      r_s_ready     <= w_s_ready_next;
      r_done        <= w_done_next;
      r_out_valid   <= w_out_valid_next;
      r_out_data    <= w_out_data_next;
      r_out_last    <= w_out_last_next;
      r_out_user    <= w_out_user_next;
      r_skid_valid  <= w_skid_valid_next;
      r_skid_data   <= w_skid_data_next;
      r_skid_last   <= w_skid_last_next;
      r_skid_user   <= w_skid_user_next;
    end
  end

  assign s_axis_tready = r_s_ready;
  assign m_axis_tdata  = r_out_data;
  assign m_axis_tvalid = r_out_valid;
  assign m_axis_tlast  = r_out_last;
  assign m_axis_tuser  = r_out_user;
  assign frame_index   = r_frame_index;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;

endmodule

// File: tb/tb_frame_stream_tx.sv
// Bench for frame_stream_tx with 4-beat frames: the model tracks accepted and emitted
// beat counts per sequence and derives every expected output from them.
module tb_frame_stream_tx;

  localparam int PPB  = 4;
  localparam int DIM  = 4;
  localparam int DW   = 8*PPB;
  localparam int MAXF = 16;
  localparam int BPF  = DIM*DIM/PPB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [4:0]    num_frames;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          m_tuser;
  logic [3:0]    frame_index;
  logic          busy;
  logic          done;

  frame_stream_tx #(
    .PIXELS_PER_BEAT(PPB),
    .IMAGE_DIM      (DIM),
    .DATA_WIDTH     (DW),
    .MAX_FRAMES     (MAXF)
  ) dut (
    .s_axis_aclk   (clk),
    .s_axis_aresetn(rst_n),
    .start         (start),
    .num_frames    (num_frames),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .frame_index   (frame_index),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  bit            active;
  int            acc_cnt, out_cnt, total, last_out_cyc;
  int            n_last, n_user, n_done, max_fi;
  logic [DW-1:0] in_log[$];
  bit            held;
  logic [63:0]   held_val;
  bit            hs;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    active       = 1'b0;
    acc_cnt      = 0;
    out_cnt      = 0;
    total        = 0;
    last_out_cyc = -10;
    held         = 1'b0;
    in_log.delete();
  endtask

  // Check the outputs of the current cycle, log handshakes, then advance one clock.
  task automatic cycle(output bit in_hs);
    bit out_hs;
    int occ;
    occ = acc_cnt - out_cnt;
    chk("s_axis_tready", 64'(s_tready), 64'(active && acc_cnt < total && occ < 2));
    chk("m_axis_tvalid", 64'(m_tvalid), 64'(occ > 0));
    chk("busy", 64'(busy), 64'(active && out_cnt < total));
    chk("done", 64'(done), 64'(active && out_cnt == total && cyc == last_out_cyc + 1));
    chk("frame_index", 64'(frame_index), 64'((acc_cnt / BPF) % MAXF));
    if (held) chk("stall_stable", {30'd0, m_tdata, m_tlast, m_tuser}, held_val);
    if (done) n_done++;
    if (int'(frame_index) > max_fi) max_fi = int'(frame_index);

    in_hs  = s_tvalid && s_tready;
    out_hs = m_tvalid && m_tready;
    if (in_hs) begin
      in_log.push_back(s_tdata);
      acc_cnt++;
    end
    if (out_hs) begin
      chk("beat_in_range", 64'(out_cnt < in_log.size()), 64'(1));
      if (out_cnt < in_log.size()) chk("beat_data", 64'(m_tdata), 64'(in_log[out_cnt]));
      chk("beat_tuser", 64'(m_tuser), 64'((out_cnt % BPF) == 0));
      chk("beat_tlast", 64'(m_tlast), 64'((out_cnt % BPF) == BPF - 1));
      if (m_tlast) n_last++;
      if (m_tuser) n_user++;
      out_cnt++;
      last_out_cyc = cyc;
    end
    held     = m_tvalid && !m_tready;
    held_val = {30'd0, m_tdata, m_tlast, m_tuser};

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_start(input int nf);
    bit h;
    num_frames = 5'(nf);
    start      = 1'b1;
    s_tvalid   = 1'b0;
    cycle(h);
    start      = 1'b0;
    if (nf >= 1 && nf <= MAXF) begin
      active       = 1'b1;
      acc_cnt      = 0;
      out_cnt      = 0;
      total        = nf * BPF;
      last_out_cyc = -10;
      n_last       = 0;
      n_user       = 0;
      n_done       = 0;
      max_fi       = 0;
      in_log.delete();
    end
  endtask

  // vmode 0: tvalid always 1 with counting data, 1: random tvalid/data.
  // rmode 0: tready always 1, 1: toggling, 2: random.
  task automatic run_seq(input int nf, input int vmode, input int rmode,
                         input int stop_acc, input bit mid_start);
    bit h;
    int budget;
    s_tdata = (vmode == 0) ? '0 : DW'($urandom);
    do_start(nf);
    budget = 0;
    while (!(out_cnt == total && cyc > last_out_cyc + 1) && budget < 2000 &&
           !(stop_acc > 0 && acc_cnt >= stop_acc)) begin
      s_tvalid   = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      m_tready   = (rmode == 0) ? 1'b1 :
                   (rmode == 1) ? ((cyc % 2) == 1) : ($urandom_range(0, 3) != 0);
      start      = mid_start && (budget == 10);
      num_frames = 5'd1;
      cycle(h);
      if (h) s_tdata = (vmode == 0) ? s_tdata + DW'(1) : DW'($urandom);
      budget++;
    end
    start    = 1'b0;
    s_tvalid = 1'b0;
    chk("seq_timeout", 64'(budget < 2000), 64'(1));
    if (stop_acc == 0) begin
      chk("beats_out", 64'(out_cnt), 64'(total));
      chk("tlast_count", 64'(n_last), 64'(nf));
      chk("tuser_count", 64'(n_user), 64'(nf));
      chk("done_count", 64'(n_done), 64'(1));
    end
    $display("sequence nf=%0d accepted=%0d emitted=%0d cycles=%0d", nf, acc_cnt, out_cnt, budget);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    num_frames = '0;
    s_tdata    = '0;
    s_tvalid   = 1'b0;
    m_tready   = 1'b0;
    n_last = 0; n_user = 0; n_done = 0; max_fi = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tready", 64'(s_tready), 64'(0));
    chk("reset_tvalid", 64'(m_tvalid), 64'(0));
    chk("reset_tdata", 64'(m_tdata), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    cycle(hs);

    // Two frames, counting data, no backpressure
    run_seq(2, 0, 0, 0, 1'b0);
    // Same with downstream ready toggling every cycle
    run_seq(2, 0, 1, 0, 1'b0);

    // Out-of-range frame counts are ignored
    do_start(0);
    do_start(17);
    repeat (8) begin
      s_tvalid = 1'b1;
      m_tready = 1'b1;
      cycle(hs);
    end
    s_tvalid = 1'b0;

    // Asynchronous reset after 6 of 8 beats
    run_seq(2, 0, 0, 6, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("midrst_tready", 64'(s_tready), 64'(0));
    chk("midrst_tvalid", 64'(m_tvalid), 64'(0));
    chk("midrst_tlast", 64'(m_tlast), 64'(0));
    chk("midrst_tuser", 64'(m_tuser), 64'(0));
    chk("midrst_tdata", 64'(m_tdata), 64'(0));
    chk("midrst_frame_index", 64'(frame_index), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    model_reset();
    repeat (3) cycle(hs);
    rst_n = 1'b1;
    cycle(hs);
    run_seq(1, 0, 0, 0, 1'b0);

    // Sixteen frames, random valid/ready, stray start mid-stream
    run_seq(16, 1, 2, 0, 1'b1);
    chk("max_frame_index", 64'(max_fi), 64'(15));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
